// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = 5;

  localparam logic [DIV_W-1:0] DIV0_Q  = 32'hFFFFFFFF;
  localparam logic [DIV_W-1:0] INT_MIN = 32'h80000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Magnitude of a two's complement value; INT_MIN maps onto itself, which reads correctly as unsigned.
  function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v, input logic take);
    return (take && ((v & INT_MIN) != '0)) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [DIV_W-1:0] dvs_i,
  output logic [DIV_W-1:0] rem_o,
  output logic             q_bit_o
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  // The partial remainder stays below the divisor, so the shifted value fits in 33 bits and
  // bit 32 of the trial difference is a true sign bit.
  always_comb begin
    shifted = {1'b0, rem_i} << 1;
    shifted[0] = dvd_msb_i;
    trial   = shifted - {1'b0, dvs_i};
    q_bit_o = ~trial[DIV_W];
    rem_o   = q_bit_o ? trial[DIV_W-1:0] : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per clock, fixed 33-cycle latency.
module div_seq
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [1:0]   dbg_state
);

  // Handshake: start is taken only while busy=0; done pulses for exactly one cycle when Q/R/div_zero
  // update, and the unit is idle (ready for start) during that same cycle.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  div_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] rem_q, rem_d;
  logic [W-1:0] dvd_q, dvd_d;
  logic [W-1:0] dvs_q, dvs_d;
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] res_r_q, res_r_d;
  logic done_q, done_d;
  logic dz_q, dz_d;

  logic [W-1:0] step_rem;
  logic         step_bit;

  div_step u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      res_r_q   <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      res_r_q   <= res_r_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    res_r_d   = res_r_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (B == '0) begin
            // Divide-by-zero answers in one cycle without entering RUN.
            quo_d   = DIV0_Q;
            res_r_d = A;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            dvd_d     = mag(A, sgn);
            dvs_d     = mag(B, sgn);
            neg_quo_d = sgn & (A[W-1] ^ B[W-1]);
            neg_rem_d = sgn & A[W-1];
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[W-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) state_d = FIN;
      end
      FIN: begin
        quo_d   = neg_quo_q ? -dvd_q : dvd_q;
        res_r_d = neg_rem_q ? -rem_q : rem_q;
        dz_d    = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Q         = quo_q;
  assign R         = res_r_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign div_zero  = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed plus randomized checks of div_seq against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Q;
  logic [31:0] R;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] exp_q[$];
  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_dz;

  div_seq #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sgn       (sgn),
    .A         (A),
    .B         (B),
    .Q         (Q),
    .R         (R),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Reference: {div_zero, Q, R} from plain arithmetic on 64-bit integers.
  function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q64, r64;
    logic [31:0] qu, ru;
    if (b == 32'd0) return {1'b1, 32'hFFFFFFFF, a};
    if (s) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q64 = sa / sb;
      r64 = sa % sb;
      qu  = q64[31:0];
      ru  = r64[31:0];
    end else begin
      qu = a / b;
      ru = a % b;
    end
    return {1'b0, qu, ru};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: issue one operation (callable in the done cycle of the previous one) and score it.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int pulse_at);
    logic [64:0] e;
    int cyc;
    logic busy_bad, hold_bad;
    exp_q.push_back(ref_div(s, a, b));
    sgn = s; A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sgn = ~s; A = $urandom(); B = $urandom();
    cyc = 0; busy_bad = 1'b0; hold_bad = 1'b0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (Q !== last_q || R !== last_r || div_zero !== last_dz) hold_bad = 1'b1;
      if (cyc == pulse_at) begin
        start = 1'b1; A = 32'd5; B = 32'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, " latency"}, 32'(cyc), (b == 32'd0) ? 32'd0 : 32'd33);
    check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, " busy_hold"}, {31'd0, busy_bad | hold_bad}, 32'd0);
    check({tag, " Q"}, Q, e[63:32]);
    check({tag, " R"}, R, e[31:0]);
    check({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, e[64]});
    last_q = e[63:32]; last_r = e[31:0]; last_dz = e[64];
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra, rb;
    int          sel;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
    last_q = '0; last_r = '0; last_dz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset Q", Q, 32'd0);
    check("reset R", R, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset div_zero", {31'd0, div_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 32'd100, 32'd7, "u100_7", -1);
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, "s-7_2", -1);
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, "s7_-2", -1);
    run_op(1'b0, 32'h1234, 32'd0, "div0_u", -1);
    run_op(1'b1, 32'h1234, 32'd0, "div0_s", -1);
    run_op(1'b0, 32'd9, 32'd3, "u9_3", -1);
    @(posedge clk); #1;
    check("done_drops", {31'd0, done}, 32'd0);
    check("dz_cleared_hold", {31'd0, div_zero}, 32'd0);

    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "s_ovf", -1);
    run_op(1'b0, 32'h80000000, 32'hFFFFFFFF, "u_ovf", -1);
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, "repulse", 5);
    run_op(1'b0, 32'd1000, 32'd33, "b2b", -1);

    // Abort an operation after ten iterations with a reset.
    sgn = 1'b0; A = 32'd12345678; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst Q", Q, 32'd0);
    check("rst R", R, 32'd0);
    last_q = '0; last_r = '0; last_dz = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 32'd1000, 32'd10, "u1000_10", -1);

    for (int i = 0; i < 30; i++) begin
      rs  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      ra  = $urandom();
      case (sel)
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 16);
        2:       rb = 32'hFFFFFFFF;
        3: begin ra = 32'h80000000; rb = $urandom(); end
        4: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 60); end
        default: rb = $urandom();
      endcase
      run_op(rs, ra, rb, "rand", -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
